// File: rtl/pid_ctrl_multi_if.sv
// Sample-request / result bundle for pid_ctrl_multi: request fields in, result and status out.
interface pid_ctrl_multi_if #(
  parameter int DW = 16,
  parameter int GW = 16
);
  logic                 i_start;
  logic                 i_clr;
  logic signed [DW-1:0] sp;
  logic signed [DW-1:0] pv;
  logic signed [GW-1:0] kp;
  logic signed [GW-1:0] ki;
  logic signed [GW-1:0] kd;
  logic signed [DW-1:0] o_u;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_sat_hi;
  logic                 o_sat_lo;
  logic                 o_overrun;

  modport master (
    output i_start, i_clr, sp, pv, kp, ki, kd,
    input  o_u, o_valid, o_busy, o_sat_hi, o_sat_lo, o_overrun
  );

  modport slave (
    input  i_start, i_clr, sp, pv, kp, ki, kd,
    output o_u, o_valid, o_busy, o_sat_hi, o_sat_lo, o_overrun
  );
endinterface

// File: rtl/pid_ctrl_multi.sv
// Velocity-form PID with one time-shared multiplier, fixed 6-cycle sequencer,
// clamped output with anti-windup, synchronous history clear and sticky overrun.
module pid_ctrl_multi #(
  parameter int DW      = 16,
  parameter int GW      = 16,
  parameter int FRAC    = 0,
  parameter int ACCW    = 40,
  parameter int OUT_MIN = 0,
  parameter int OUT_MAX = 32767
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pid_ctrl_multi_if.slave bus
);
  localparam int EW = DW + 1;
  localparam int XW = DW + 3;
  localparam int PW = GW + DW + 3;
  localparam logic signed [ACCW-1:0] OMIN_A = ACCW'(OUT_MIN);
  localparam logic signed [ACCW-1:0] OMAX_A = ACCW'(OUT_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    MUL_P = 3'd2,
    MUL_I = 3'd3,
    MUL_D = 3'd4,
    ACC   = 3'd5,
    SAT   = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic signed [DW-1:0]   sp_q, sp_d, pv_q, pv_d, u_q, u_d;
  logic signed [GW-1:0]   kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [EW-1:0]   e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [XW-1:0]   d1_q, d1_d, d2_q, d2_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic signed [ACCW-1:0] sum_q, sum_d, pre_q, pre_d;
  logic                   valid_q, valid_d, busy_q, busy_d;
  logic                   sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d, ovr_q, ovr_d;

  logic signed [EW-1:0]   err_s;
  logic signed [GW-1:0]   mul_g_s;
  logic signed [XW-1:0]   mul_x_s;
  logic signed [PW-1:0]   mul_s;
  logic signed [ACCW-1:0] tot_s;

  // Shared multiplier: operand pair chosen by the current multiply state.
  always_comb begin
    mul_g_s = kd_q;
    mul_x_s = d2_q;
    case (state_q)
      MUL_P:   begin mul_g_s = kp_q; mul_x_s = d1_q;        end
      MUL_I:   begin mul_g_s = ki_q; mul_x_s = XW'(e0_q);   end
      default: begin mul_g_s = kd_q; mul_x_s = d2_q;        end
    endcase
    mul_s = PW'(mul_g_s) * PW'(mul_x_s);
    err_s = EW'(sp_q) - EW'(pv_q);
    tot_s = sum_q + ACCW'(prod_q);
  end

  // Sequencer next-state and datapath updates; clear overrides everything.
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    pv_d     = pv_q;
    kp_d     = kp_q;
    ki_d     = ki_q;
    kd_d     = kd_q;
    e0_d     = e0_q;
    e1_d     = e1_q;
    e2_d     = e2_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    prod_d   = prod_q;
    sum_d    = sum_q;
    pre_d    = pre_q;
    u_d      = u_q;
    valid_d  = 1'b0;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    ovr_d    = ovr_q;
    if (bus.i_clr) begin
      state_d  = IDLE;
      u_d      = '0;
      e1_d     = '0;
      e2_d     = '0;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
      ovr_d    = 1'b0;
    end else begin
      ovr_d = ovr_q | (bus.i_start & (state_q != IDLE));
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            state_d = ERR;
            sp_d    = bus.sp;
            pv_d    = bus.pv;
            kp_d    = bus.kp;
            ki_d    = bus.ki;
            kd_d    = bus.kd;
          end else begin
            state_d = IDLE;
          end
        end
        ERR: begin
          e0_d    = err_s;
          d1_d    = XW'(err_s) - XW'(e1_q);
          d2_d    = XW'(err_s) - (XW'(e1_q) <<< 1) + XW'(e2_q);
          state_d = MUL_P;
        end
        MUL_P: begin
          prod_d  = mul_s;
          state_d = MUL_I;
        end
        MUL_I: begin
          prod_d  = mul_s;
          sum_d   = ACCW'(prod_q);
          state_d = MUL_D;
        end
        MUL_D: begin
          prod_d  = mul_s;
          sum_d   = sum_q + ACCW'(prod_q);
          state_d = ACC;
        end
        ACC: begin
          pre_d   = ACCW'(u_q) + (tot_s >>> FRAC);
          state_d = SAT;
        end
        SAT: begin
          // Storing the clamped value keeps the integrator from winding up.
          sat_hi_d = (pre_q > OMAX_A);
          sat_lo_d = (pre_q < OMIN_A);
          if (pre_q > OMAX_A) begin
            u_d = DW'(OMAX_A);
          end else if (pre_q < OMIN_A) begin
            u_d = DW'(OMIN_A);
          end else begin
            u_d = DW'(pre_q);
          end
          e2_d    = e1_q;
          e1_d    = e0_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sp_q     <= '0;
      pv_q     <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      kd_q     <= '0;
      e0_q     <= '0;
      e1_q     <= '0;
      e2_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      prod_q   <= '0;
      sum_q    <= '0;
      pre_q    <= '0;
      u_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      pv_q     <= pv_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      kd_q     <= kd_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      prod_q   <= prod_d;
      sum_q    <= sum_d;
      pre_q    <= pre_d;
      u_q      <= u_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.o_u       = u_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_sat_hi  = sat_hi_q;
  assign bus.o_sat_lo  = sat_lo_q;
  assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_pid_ctrl_multi.sv
// Directed bench for pid_ctrl_multi: hand-computed samples checked with immediate assertions.
module tb_pid_ctrl_multi;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   lat;
  int   pulses;

  pid_ctrl_multi_if #(.DW(16), .GW(16)) bif ();

  pid_ctrl_multi #(
    .DW(16), .GW(16), .FRAC(0), .ACCW(40), .OUT_MIN(0), .OUT_MAX(32767)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input int p, input int gp, input int gi, input int gd);
    bif.sp = 16'(s);
    bif.pv = 16'(p);
    bif.kp = 16'(gp);
    bif.ki = 16'(gi);
    bif.kd = 16'(gd);
  endtask

  // Issue one request and wait (bounded) for its result pulse.
  task automatic run_sample(input string tag, input int s, input int p, input int gp,
                            input int gi, input int gd, input int exp_u,
                            input int exp_hi, input int exp_lo);
    @(negedge clk);
    drive(s, p, gp, gi, gd);
    bif.i_start = 1'b1;
    @(posedge clk);
    #1;
    bif.i_start = 1'b0;
    check({tag, "_busy"}, bif.o_busy, 1);
    lat = 0;
    while (!bif.o_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 6);
    check({tag, "_u"}, bif.o_u, exp_u);
    check({tag, "_hi"}, bif.o_sat_hi, exp_hi);
    check({tag, "_lo"}, bif.o_sat_lo, exp_lo);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, bif.o_valid, 0);
    check({tag, "_idle"}, bif.o_busy, 0);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    bif.i_clr = 1'b1;
    @(posedge clk);
    #1;
    bif.i_clr = 1'b0;
    check({tag, "_u0"}, bif.o_u, 0);
    check({tag, "_ovr0"}, bif.o_overrun, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bif.i_start = 1'b0;
    bif.i_clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_u", bif.o_u, 0);
    check("rst_valid", bif.o_valid, 0);
    check("rst_busy", bif.o_busy, 0);
    check("rst_ovr", bif.o_overrun, 0);
    rst_n = 1'b1;

    // Proportional only
    run_sample("p1", 100, 0, 2, 0, 0, 200, 0, 0);
    run_sample("p2", 100, 0, 2, 0, 0, 200, 0, 0);

    // Reset in the middle of a computation, then a clean-history sample
    @(negedge clk);
    drive(50, 0, 2, 0, 0);
    bif.i_start = 1'b1;
    @(posedge clk);
    #1;
    bif.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_u", bif.o_u, 0);
    check("mrst_busy", bif.o_busy, 0);
    check("mrst_valid", bif.o_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample("post_rst", 100, 0, 2, 0, 0, 200, 0, 0);

    // Integral only
    do_clear("clr_i");
    run_sample("i1", 10, 0, 0, 3, 0, 30, 0, 0);
    run_sample("i2", 10, 0, 0, 3, 0, 60, 0, 0);
    run_sample("i3", 10, 0, 0, 3, 0, 90, 0, 0);

    // Saturation and anti-windup
    do_clear("clr_s");
    run_sample("s1", 20, 0, 0, 1000, 0, 20000, 0, 0);
    run_sample("s2", 20, 0, 0, 1000, 0, 32767, 1, 0);
    run_sample("s3", 0, 20, 0, 1000, 0, 12767, 0, 0);

    // Derivative only; last step drives the unclamped value below OUT_MIN
    do_clear("clr_d");
    run_sample("d1", 0, 0, 0, 0, 1, 0, 0, 0);
    run_sample("d2", 10, 0, 0, 0, 1, 10, 0, 0);
    run_sample("d3", 10, 0, 0, 0, 1, 0, 0, 0);
    run_sample("d4", 0, 10, 0, 0, 1, 0, 0, 1);

    // Overrun: a second start at t0+2 is dropped, the first result still arrives
    do_clear("clr_o");
    @(negedge clk);
    drive(100, 0, 2, 0, 0);
    bif.i_start = 1'b1;
    @(posedge clk);
    #1;
    bif.i_start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    bif.i_start = 1'b1;
    @(posedge clk);
    #1;
    bif.i_start = 1'b0;
    lat = 2;
    check("ovr_set", bif.o_overrun, 1);
    while (!bif.o_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ovr_lat", lat, 6);
    check("ovr_u", bif.o_u, 200);
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bif.o_valid) pulses++;
    end
    check("ovr_single", pulses, 0);
    check("ovr_sticky", bif.o_overrun, 1);
    do_clear("clr_ovr");

    // Clear together with start: nothing starts and overrun stays low
    @(negedge clk);
    drive(100, 0, 2, 0, 0);
    bif.i_clr = 1'b1;
    bif.i_start = 1'b1;
    @(posedge clk);
    #1;
    bif.i_clr = 1'b0;
    bif.i_start = 1'b0;
    check("cs_busy", bif.o_busy, 0);
    check("cs_ovr", bif.o_overrun, 0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bif.o_valid) pulses++;
    end
    check("cs_nores", pulses, 0);
    check("cs_u", bif.o_u, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pid_ctrl_multi.md
Name: pid_ctrl_multi

Overview:
Parametrised successor to the team's single-channel velocity-form PID block, used in the motor/velocity S-curve path. It computes an incremental PID update per sample from setpoint and process value, using one time-shared multiplier and a fixed-latency sequencer. It adds the following over the previous generation:
- configurable width and fixed-point gain scaling;
- output saturation with anti-windup;
- an explicit start/valid handshake;
- a synchronous history clear;
- overrun detection.

Parameters:
DW, 16, signed data width of sp, pv and o_u.
GW, 16, signed gain width of kp, ki, kd.
FRAC, 0, gain fraction bits; the summed product is arithmetic-right-shifted by FRAC (floor).
ACCW, 40, internal accumulator width; must be >= DW+GW+5.
OUT_MIN, 0, lower saturation bound (signed, fits DW).
OUT_MAX, 32767, upper saturation bound (signed, fits DW, > OUT_MIN).

Ports:
i_clk  in  1  system clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  one-cycle sample request; accepted only when o_busy=0.
i_clr  in  1  synchronous clear of history, output and flags.
sp  in  DW  signed setpoint; sampled on the accepting edge.
pv  in  DW  signed process value; sampled on the accepting edge.
kp  in  GW  signed proportional gain; sampled on the accepting edge.
ki  in  GW  signed integral gain; sampled on the accepting edge.
kd  in  GW  signed derivative gain; sampled on the accepting edge.
o_u  out  DW  signed saturated control output; holds its value between updates.
o_valid  out  1  one-cycle pulse when o_u updates.
o_busy  out  1  high while a computation is in flight.
o_sat_hi  out  1  last result clamped to OUT_MAX.
o_sat_lo  out  1  last result clamped to OUT_MIN.
o_overrun  out  1  sticky; i_start arrived while busy.

Behaviour:
- Reset (i_rst_n=0, async): all outputs 0; e1=e2=0; u=0; state IDLE.
- Per accepted sample, all arithmetic is sign-extended to ACCW with no intermediate overflow:
  - e0 = sp - pv.
  - d1 = e0 - e1.
  - d2 = e0 - 2*e1 + e2.
  - delta = (kp*d1 + ki*e0 + kd*d2) >>> FRAC.
  - u_new = clamp(u + delta, OUT_MIN, OUT_MAX).
- Anti-windup: the stored u is the clamped value, so no excess is accumulated.
- On the result edge: u <= u_new; o_u <= u_new[DW-1:0]; e2 <= e1; e1 <= e0.
  - o_sat_hi = (u + delta > OUT_MAX).
  - o_sat_lo = (u + delta < OUT_MIN).
- State machine, one state per cycle: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> ACC -> SAT -> IDLE.
  - ERR: latch e0, d1, d2.
  - MUL_P / MUL_I / MUL_D: a single GW x (DW+3) signed multiplier, registered output, accumulated into the sum register.
  - ACC: apply the shift and add u.
  - SAT: clamp and register the outputs.
- Latency and handshake:
  - i_start sampled high at edge t0 while IDLE moves the FSM to ERR.
  - o_busy is high from after t0 until after t0+6.
  - o_u, o_valid and the sat flags update at edge t0+6.
  - o_valid is high for exactly one cycle.
  - Back-to-back: i_start at t0+6 is accepted (o_busy is still 1 at that edge? No: o_busy must already be low in the cycle before t0+6... the acceptance rule is evaluated on o_busy as registered, so i_start at t0+6 is NOT accepted; the earliest accepting edge is t0+7).
- i_start while busy: dropped; o_overrun <= 1 (sticky); the computation in flight continues unaffected.
- i_clr (any state):
  - Next edge: FSM to IDLE, any in-flight computation aborted with no o_valid.
  - u, e1, e2, o_u, the sat flags and o_overrun are all cleared to 0.
- i_clr and i_start on the same edge: clear wins; start is dropped and does not set o_overrun.
- Gains sampled per request, so a gain change takes effect on the next sample; no bumpless transfer is required.
- OUT_MIN = 0 reproduces the earlier "negative clamps to zero" behaviour.

Test Plan:
1. Reset: hold i_rst_n=0 mid-computation -> all outputs 0 immediately; after release, the first sample behaves as if from a clean history.
2. P only (kp=2, ki=kd=0):
   - sp=100, pv=0 -> o_valid at t0+6, o_u=200.
   - Repeat the same sample -> o_u=200 (d1=0, d2=0).
3. I only (ki=3): three samples with sp=10, pv=0 -> o_u=30, 60, 90; flags 0.
4. Saturation and anti-windup (ki=1000, kp=kd=0):
   - sp=20, pv=0 -> 20000.
   - Same again -> 32767, o_sat_hi=1.
   - sp=0, pv=20 -> 12767, o_sat_hi=0.
5. D only (kd=1): errors 0, 10, 10 -> o_u=0, 10, 0. The third sample has d2=-10, so o_sat_lo=0 because the unclamped value is exactly 0.
6. Overrun and clear:
   - i_start at t0+2 -> o_overrun=1; the single o_valid at t0+6 still arrives.
   - Then i_clr -> o_u=0, o_overrun=0.
   - i_clr together with i_start -> no computation, o_overrun stays 0.
   - Optional variant: FRAC=4, kp=16, e=5 -> o_u=5.
